fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the RV pipeline. Owns the program counter, drives the combinational instruction memory address, and captures the returned word into the IF/ID pipeline register.
- Handles load-use stalls, branch/jump redirect from EX, and decode flushes.
- Substitutes a NOP for out-of-range fetches and counts fetched instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 64, number of valid 32-bit words in instruction memory; legal fetch range is 0 to 4*IMEM_WORDS-1.
- NOP_INSTR, 32'h0000_0013, encoding of addi x0,x0,0, injected on flush, reset or fault.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold PC this cycle.
- stall_d  in  1  hold IF/ID register this cycle.
- flush_d  in  1  replace IF/ID contents with a bubble.
- pc_src_e  in  1  redirect request from EX (taken branch or jump).
- pc_target_e  in  32  redirect target from EX.
- imem_addr  out  32  address to instruction memory; equals current PC (pc_f).
- imem_rd  in  32  combinational read data from instruction memory.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real fetched instruction.
- fetch_fault_d  out  1  IF/ID instruction came from an out-of-range PC.
- misalign_f  out  1  one-cycle pulse: the accepted redirect target had bits[1:0] != 0.
- fetch_count  out  32  number of instructions accepted into IF/ID.

Behaviour:
- Reset (async on rst_n=0, released synchronously to the logic):
  - pc_f=RESET_PC; instr_d=NOP_INSTR; pc_d=0; pc_plus4_d=0.
  - valid_d=0; fetch_fault_d=0; misalign_f=0; fetch_count=0.
- imem_addr=pc_f combinationally. Memory read is zero-latency, so the instruction at pc_f is captured at the next edge: one-cycle IF latency.
- Next-PC priority, highest first:
  1. pc_src_e=1: pc_f <= {pc_target_e[31:2],2'b00}. Stall_f is overridden because the redirect must not be lost. misalign_f<=1 for one cycle if pc_target_e[1:0]!=0, else 0.
  2. stall_f=1: pc_f unchanged.
  3. Otherwise: pc_f <= pc_f+4, wrapping modulo 2^32 with no error.
- Out-of-range PC: pc_f >= 4*IMEM_WORDS sets fault_f=1 (internal).
  - The captured instruction is NOP_INSTR instead of imem_rd.
  - The PC keeps advancing normally; the fault is flagged and does not halt fetch.
- IF/ID register priority, highest first:
  1. flush_d=1: instr_d=NOP_INSTR; valid_d=0; fetch_fault_d=0; pc_d and pc_plus4_d are don't-care (driven 0). flush_d also beats stall_d.
  2. stall_d=1: all IF/ID fields hold.
  3. Otherwise: instr_d<=fault_f?NOP_INSTR:imem_rd; pc_d<=pc_f; pc_plus4_d<=pc_f+4; valid_d<=1; fetch_fault_d<=fault_f.
- fetch_count increments by 1 on each edge where an IF/ID load of case 3 occurs. It saturates at 32'hFFFF_FFFF.
- Simultaneous pc_src_e=1 and flush_d=1 is the normal taken-branch case:
  - The wrong-path instruction in IF is dropped.
  - The target is fetched the following cycle.
  - The hazard unit also flushes EX; that is outside this block.
- Simultaneous stall_f=1 and stall_d=0 is legal (a bubble is not inserted here). instr_d reloads the same PC, and valid_d=1.
- Reset asserted mid-operation: all state returns to reset values immediately, with no partial update.

Decomposition:
- Shared package rv_pkg holds:
  - constants NOP_INSTR and XLEN=32;
  - a struct if_id_t {instr, pc, pc_plus4, valid, fault} reused by decode.
- One sub-module, pc_reg: PC register plus next-PC mux, alignment masking and misalign pulse.
- The IF/ID register and counter stay in fetch_stage.

Test Plan:
- Reset release, no stalls, memory word k = 32'h1000_0000+k -> imem_addr sequence 0,4,8,…; instr_d on cycle n+1 = 32'h1000_0000+n; valid_d=1 from first edge; fetch_count=3 after three edges.
- stall_f=1 and stall_d=1 for 2 cycles at pc_f=8 -> imem_addr stays 8; instr_d/pc_d frozen at word 1/4; fetch_count unchanged; resume gives pc_d=8.
- pc_src_e=1, pc_target_e=32'h40, flush_d=1 at pc_f=0x10 -> next cycle imem_addr=0x40, instr_d=32'h13, valid_d=0; following cycle pc_d=0x40.
- pc_src_e=1, pc_target_e=32'h22, with stall_f=1 -> pc_f=0x20 (redirect wins over stall); misalign_f=1 for exactly one cycle.
- Run PC to 0x100 with IMEM_WORDS=64 -> instr_d=32'h13, fetch_fault_d=1, valid_d=1; PC continues to 0x104.
- Assert rst_n=0 mid-stream at pc_f=0x2C, between clock edges -> all outputs at reset values immediately; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV pipeline constants and the IF/ID record
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            fault;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - hazard, instruction memory and IF/ID signals of the fetch stage
interface fetch_stage_if;
  import rv_pkg::*;

  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rd;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            valid_d;
  logic            fetch_fault_d;
  logic            misalign_f;
  logic [31:0]     fetch_count;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rd,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault_d,
           misalign_f, fetch_count
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rd,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault_d,
           misalign_f, fetch_count
  );
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter with redirect/stall next-PC selection
module pc_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] pc_f,
  output logic            misalign_f
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      misalign_f <= 1'b0;
    end else begin
      misalign_f <= pc_src_e && (pc_target_e[1:0] != 2'b00);
      // A redirect must never be lost, so it overrides a PC stall.
      if (pc_src_e)
        pc_f <= {pc_target_e[XLEN-1:2], 2'b00};
      else if (!stall_f)
        pc_f <= pc_f + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction capture into IF/ID, fault NOP substitution, fetch counter
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_WORDS = 64,
  parameter logic [XLEN-1:0] NOP_INSTR  = rv_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_WORDS);

  logic [XLEN-1:0] pc_f;
  logic            fault_f;
  logic            load_d;
  if_id_t          if_id_q;
  logic [31:0]     fetch_count_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (bus.stall_f),
    .pc_src_e    (bus.pc_src_e),
    .pc_target_e (bus.pc_target_e),
    .pc_f        (pc_f),
    .misalign_f  (bus.misalign_f)
  );

  assign bus.imem_addr = pc_f;
  assign fault_f       = (pc_f >= IMEM_BYTES);
  assign load_d        = !bus.flush_d && !bus.stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q       <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0, fault: 1'b0};
      fetch_count_q <= '0;
    end else begin
      if (bus.flush_d)
        if_id_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0, fault: 1'b0};
      else if (load_d)
        if_id_q <= '{instr:    fault_f ? NOP_INSTR : bus.imem_rd,
                     pc:       pc_f,
                     pc_plus4: pc_f + XLEN'(4),
                     valid:    1'b1,
                     fault:    fault_f};
      if (load_d && (fetch_count_q != 32'hFFFF_FFFF))
        fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign bus.instr_d       = if_id_q.instr;
  assign bus.pc_d          = if_id_q.pc;
  assign bus.pc_plus4_d    = if_id_q.pc_plus4;
  assign bus.valid_d       = if_id_q.valid;
  assign bus.fetch_fault_d = if_id_q.fault;
  assign bus.fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized run against a reference model
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'd256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (64),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sf, sd, fl, src;
    logic [31:0] tgt;
    logic [31:0] addr, instr, pcd;
    logic        valid, fault, mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[16];

  logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
  logic        m_valid, m_fault, m_mis;

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_p4 = 0;
    m_valid = 0; m_fault = 0; m_mis = 0; m_cnt = 0;
  endtask

  task automatic model_step(logic sf, logic sd, logic fl, logic src, logic [31:0] tgt);
    logic in_range;
    in_range = (m_pc < LIMIT);
    if (fl) begin
      m_instr = NOP; m_pcd = 0; m_p4 = 0; m_valid = 0; m_fault = 0;
    end else if (!sd) begin
      m_instr = in_range ? mem_word(m_pc) : NOP;
      m_pcd = m_pc; m_p4 = m_pc + 4; m_valid = 1; m_fault = !in_range;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    m_mis = src && (tgt % 4 != 0);
    if (src) m_pc = tgt - (tgt % 4);
    else if (!sf) m_pc = m_pc + 4;
  endtask

  task automatic drive(logic sf, logic sd, logic fl, logic src, logic [31:0] tgt);
    bus.stall_f = sf; bus.stall_d = sd; bus.flush_d = fl;
    bus.pc_src_e = src; bus.pc_target_e = tgt;
  endtask

  task automatic check_all(string tag, logic [31:0] addr, logic [31:0] instr, logic [31:0] pcd,
                           logic [31:0] p4, logic valid, logic fault, logic mis, logic [31:0] cnt);
    chk({tag, ".imem_addr"}, bus.imem_addr, addr);
    chk({tag, ".instr_d"}, bus.instr_d, instr);
    chk({tag, ".pc_d"}, bus.pc_d, pcd);
    chk({tag, ".pc_plus4_d"}, bus.pc_plus4_d, p4);
    chk({tag, ".valid_d"}, {31'b0, bus.valid_d}, {31'b0, valid});
    chk({tag, ".fetch_fault_d"}, {31'b0, bus.fetch_fault_d}, {31'b0, fault});
    chk({tag, ".misalign_f"}, {31'b0, bus.misalign_f}, {31'b0, mis});
    chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    tv[0]  = '{0,0,0,0, 32'h0,  32'h04,  32'h1000_0000, 32'h00,  1,0,0, 1};
    tv[1]  = '{0,0,0,0, 32'h0,  32'h08,  32'h1000_0001, 32'h04,  1,0,0, 2};
    tv[2]  = '{1,1,0,0, 32'h0,  32'h08,  32'h1000_0001, 32'h04,  1,0,0, 2};
    tv[3]  = '{1,1,0,0, 32'h0,  32'h08,  32'h1000_0001, 32'h04,  1,0,0, 2};
    tv[4]  = '{0,0,0,0, 32'h0,  32'h0C,  32'h1000_0002, 32'h08,  1,0,0, 3};
    tv[5]  = '{0,0,0,0, 32'h0,  32'h10,  32'h1000_0003, 32'h0C,  1,0,0, 4};
    tv[6]  = '{0,0,1,1, 32'h40, 32'h40,  NOP,           32'h00,  0,0,0, 4};
    tv[7]  = '{0,0,0,0, 32'h0,  32'h44,  32'h1000_0010, 32'h40,  1,0,0, 5};
    tv[8]  = '{1,0,0,1, 32'h22, 32'h20,  32'h1000_0011, 32'h44,  1,0,1, 6};
    tv[9]  = '{1,0,0,0, 32'h0,  32'h20,  32'h1000_0008, 32'h20,  1,0,0, 7};
    tv[10] = '{0,0,0,0, 32'h0,  32'h24,  32'h1000_0008, 32'h20,  1,0,0, 8};
    tv[11] = '{0,0,1,1, 32'hF8, 32'hF8,  NOP,           32'h00,  0,0,0, 8};
    tv[12] = '{0,0,0,0, 32'h0,  32'hFC,  32'h1000_003E, 32'hF8,  1,0,0, 9};
    tv[13] = '{0,0,0,0, 32'h0,  32'h100, 32'h1000_003F, 32'hFC,  1,0,0, 10};
    tv[14] = '{0,0,0,0, 32'h0,  32'h104, NOP,           32'h100, 1,1,0, 11};
    tv[15] = '{0,1,1,0, 32'h0,  32'h108, NOP,           32'h00,  0,0,0, 11};

    drive(0, 0, 0, 0, 0);
    #12;
    check_all("reset", 32'h0, NOP, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].sf, tv[i].sd, tv[i].fl, tv[i].src, tv[i].tgt);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), tv[i].addr, tv[i].instr, tv[i].pcd,
                tv[i].valid ? tv[i].pcd + 32'd4 : 32'd0,
                tv[i].valid, tv[i].fault, tv[i].mis, tv[i].cnt);
    end

    // Asynchronous reset between edges while running at 0x2C.
    drive(0, 0, 1, 1, 32'h28);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("midreset.pre_addr", bus.imem_addr, 32'h2C);
    #2 rst_n = 1'b0;
    #1;
    check_all("midreset", 32'h0, NOP, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset.release_addr", bus.imem_addr, 32'h0);

    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic sf, sd, fl, src;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 3) == 0);
      sd  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      src = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                        : $urandom_range(0, 32'h13F);
      drive(sf, sd, fl, src, tgt);
      model_step(sf, sd, fl, src, tgt);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_instr, m_pcd, m_p4, m_valid, m_fault, m_mis, m_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
